next_pc_gen: RTL

- Next-PC generation stage directly upstream of the PC register. Computes the value the PC register loads each cycle from the current fetch PC.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for fetch-time prediction.
- Accepts resolved branch/jump outcomes from EX. On a misprediction it raises a redirect and flush.
- Keeps two performance counters.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_btb.sv | 69 ++++++
 rtl/next_pc_gen.sv | 88 ++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch prediction slice: counter encodings,
// default BTB geometry and the instruction size.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    localparam int          BTB_ENTRIES_DEFAULT = 16;
    localparam logic [31:0] INSN_SIZE           = 32'd4;

    function automatic cnt_t cnt_inc(input cnt_t c);
        cnt_t r;
        case (c)
            SNT:     r = WNT;
            WNT:     r = WT;
            default: r = ST;
        endcase
        return r;
    endfunction

    function automatic cnt_t cnt_dec(input cnt_t c);
        cnt_t r;
        case (c)
            ST:      r = WT;
            WT:      r = WNT;
            default: r = SNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup port and a
// clocked update port applying the 2-bit saturating counter policy.
module bp_btb
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter int IDX_W       = $clog2(BTB_ENTRIES),
    parameter int TAG_W       = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic             rd_taken,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic             wr_jump,
    input  logic [31:0]      wr_target
);

    logic             valid_arr [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_arr   [BTB_ENTRIES];
    logic [31:0]      tgt_arr   [BTB_ENTRIES];
    cnt_t             cnt_arr   [BTB_ENTRIES];

    logic wr_hit;

    always_comb begin
        rd_hit    = valid_arr[rd_idx] && (tag_arr[rd_idx] == rd_tag);
        rd_taken  = rd_hit && cnt_arr[rd_idx][1];
        rd_target = rd_hit ? tgt_arr[rd_idx] : 32'd0;
        wr_hit    = valid_arr[wr_idx] && (tag_arr[wr_idx] == wr_tag);
    end

    // Lookup above reads the pre-edge contents, so a same-index update is read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_arr[i] <= 1'b0;
                tag_arr[i]   <= '0;
                tgt_arr[i]   <= '0;
                cnt_arr[i]   <= WNT;
            end
        end else if (wr_en) begin
            if (wr_jump) begin
                valid_arr[wr_idx] <= 1'b1;
                tag_arr[wr_idx]   <= wr_tag;
                tgt_arr[wr_idx]   <= wr_target;
                cnt_arr[wr_idx]   <= ST;
            end else if (wr_taken) begin
                tgt_arr[wr_idx] <= wr_target;
                if (wr_hit) begin
                    cnt_arr[wr_idx] <= cnt_inc(cnt_arr[wr_idx]);
                end else begin
                    valid_arr[wr_idx] <= 1'b1;
                    tag_arr[wr_idx]   <= wr_tag;
                    cnt_arr[wr_idx]   <= WT;
                end
            end else if (wr_hit) begin
                cnt_arr[wr_idx] <= cnt_dec(cnt_arr[wr_idx]);
            end
        end
    end

endmodule

// File: rtl/next_pc_gen.sv
// Next-PC generation: BTB prediction at fetch, branch resolution from EX,
// mispredict redirect/flush and performance counters.
module next_pc_gen
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter int IDX_W       = $clog2(BTB_ENTRIES),
    parameter int TAG_W       = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pipeline_stop,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic [31:0] next_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        flush,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    logic        lookup_hit;
    logic        ctrl;
    logic        res_taken;
    logic        mispredict;
    logic [31:0] correct_pc;

    bp_btb #(
        .BTB_ENTRIES(BTB_ENTRIES),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_btb (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc[IDX_W+1:2]),
        .rd_tag   (pc[31:IDX_W+2]),
        .rd_hit   (lookup_hit),
        .rd_taken (pred_taken),
        .rd_target(pred_target),
        .wr_en    (ctrl && !pipeline_stop),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_tag   (ex_pc[31:IDX_W+2]),
        .wr_taken (res_taken),
        .wr_jump  (ex_is_jump),
        .wr_target(ex_target)
    );

    // A branch+jump report is illegal; jump dominates because res_taken ORs it in.
    always_comb begin
        ctrl       = ex_valid && (ex_is_branch || ex_is_jump);
        res_taken  = ex_is_jump || (ex_is_branch && ex_taken);
        mispredict = ctrl && ((ex_pred_taken != res_taken) ||
                              (res_taken && (ex_pred_target != ex_target)));
        correct_pc = res_taken ? ex_target : (ex_pc + INSN_SIZE);
        flush      = mispredict;
        if (mispredict) begin
            next_pc = correct_pc;
        end else if (pred_taken) begin
            next_pc = pred_target;
        end else begin
            next_pc = pc + INSN_SIZE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (ctrl && !pipeline_stop) begin
            perf_branches <= perf_branches + 32'd1;
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end

    logic unused_hit;
    assign unused_hit = lookup_hit;

endmodule
